instr_prefetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the cpu execute stage. It autonomously fetches sequential 32-bit instruction words over a single-outstanding request/acknowledge memory port. Fetched words are buffered together with their word address in a small FIFO and handed to decode through a valid/ready handshake. A redirect input (taken branch or address change from the ALU) flushes the queue and restarts fetch at a new address.

---
 rtl/instr_prefetch_queue.sv | 159 +++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a single-outstanding
// req/ack port, buffers {pc, instr} in a DEPTH-entry FIFO, and hands them to
// decode via valid/ready. A redirect flushes the queue and restarts fetch.
// Optional build macro PREFETCH_BYPASS_EN: forward an acked word straight to
// out_* when the queue is empty (combinational mem_* -> out_* path).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding (queue full or just redirected)
// REQ      | request outstanding at mem_addr, data will be queued
// DISCARD  | request outstanding from before a redirect, data dropped
module instr_prefetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       mem_req,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic                       mem_ack,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   input  logic                       out_ready,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [CW-1:0]     r_count, w_count_nxt;
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [DATA_W-1:0] r_q_instr [DEPTH];
   logic [ADDR_W-1:0] r_q_pc    [DEPTH];
   logic              w_ack_ok, w_head_valid, w_push, w_pop, w_byp_take;

   assign w_ack_ok     = (r_state == S_REQ) && mem_ack;
   assign w_head_valid = (r_count != '0);
   assign w_pc_inc     = r_fetch_pc + ADDR_W'(1);
   assign w_pop        = w_head_valid && out_ready && !redirect;
   assign w_push       = w_ack_ok && !redirect && !w_byp_take;

   assign mem_req  = (r_state != S_IDLE);
   assign mem_addr = r_mem_addr;
   assign count    = r_count;

`ifdef PREFETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass   = (r_count == '0) && w_ack_ok && !redirect;
   assign w_byp_take = w_bypass && out_ready;
   assign out_valid  = w_head_valid || w_bypass;
   assign out_instr  = w_bypass ? mem_rdata  : r_q_instr[r_rd_ptr];
   assign out_pc     = w_bypass ? r_mem_addr : r_q_pc[r_rd_ptr];
`else
   assign w_byp_take = 1'b0;
   assign out_valid  = w_head_valid;
   assign out_instr  = r_q_instr[r_rd_ptr];
   assign out_pc     = r_q_pc[r_rd_ptr];
`endif

   // Next-state, fetch PC, request address and occupancy
   always_comb begin
      w_state_nxt    = r_state;
      w_mem_addr_nxt = r_mem_addr;
      w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
      w_fetch_pc_nxt = r_fetch_pc;
      if (redirect) begin
         w_count_nxt    = '0;
         w_fetch_pc_nxt = redirect_pc;
      end else if (w_ack_ok) begin
         w_fetch_pc_nxt = w_pc_inc;
      end
      case (r_state)
         S_IDLE: begin
            if (!redirect && (r_count < CW'(DEPTH))) begin
               w_state_nxt    = S_REQ;
               w_mem_addr_nxt = r_fetch_pc;
            end
         end
         S_REQ: begin
            if (redirect) begin
               if (mem_ack) begin
                  // Queue is empty after the flush, so a new request always fits
                  w_state_nxt    = S_REQ;
                  w_mem_addr_nxt = redirect_pc;
               end else begin
                  // Bus cannot abort: hold the old request and drop its data later
                  w_state_nxt = S_DISCARD;
               end
            end else if (mem_ack) begin
               if (w_count_nxt < CW'(DEPTH)) begin
                  w_state_nxt    = S_REQ;
                  w_mem_addr_nxt = w_pc_inc;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            if (mem_ack) begin
               w_state_nxt    = S_REQ;
               w_mem_addr_nxt = redirect ? redirect_pc : r_fetch_pc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_mem_addr <= RESET_PC;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_count    <= w_count_nxt;
         if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Queue storage; cleared on reset so the head reads zero out of reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else if (w_push) begin
         r_q_instr[r_wr_ptr] <= mem_rdata;
         r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (default build, no bypass).
module tb_instr_prefetch_queue;

   logic        clock;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rst;
      bit          ack;
      logic [31:0] rdata;
      bit          ready;
      bit          e_req;
      bit          ca;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   instr_prefetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .count       (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(bit rst, bit ack, logic [31:0] rdata, bit ready,
                               bit e_req, bit ca, logic [31:0] e_addr, bit e_valid,
                               logic [31:0] e_pc, logic [31:0] e_instr, logic [2:0] e_cnt);
      vec_t v;
      v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
      v.e_req = e_req; v.ca = ca; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, " mem_req"},   32'(mem_req),   32'(v.e_req));
      if (v.ca) chk({tag, " mem_addr"}, mem_addr, v.e_addr);
      chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_valid));
      if (v.e_valid || v.rst) begin
         chk({tag, " out_pc"},    out_pc,    v.e_pc);
         chk({tag, " out_instr"}, out_instr, v.e_instr);
      end
      chk({tag, " count"},     32'(count),     32'(v.e_cnt));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic step(input bit ack, input logic [31:0] rdata, input bit ready,
                       input bit redir, input logic [31:0] rpc);
      mem_ack = ack; mem_rdata = rdata; out_ready = ready;
      redirect = redir; redirect_pc = rpc;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

      // Streaming with ack every cycle and decode always ready
      tbl.push_back(mk(1,0,32'h0,   0, 0,1,32'h0,0,32'h0,32'h0,   3'd0));
      tbl.push_back(mk(0,1,32'h1000,1, 1,1,32'h0,0,32'h0,32'h0,   3'd0));
      tbl.push_back(mk(0,1,32'h1000,1, 1,1,32'h1,1,32'h0,32'h1000,3'd1));
      tbl.push_back(mk(0,1,32'h1001,1, 1,1,32'h2,1,32'h1,32'h1001,3'd1));
      tbl.push_back(mk(0,1,32'h1002,1, 1,1,32'h3,1,32'h2,32'h1002,3'd1));
      tbl.push_back(mk(0,1,32'h1003,1, 1,1,32'h4,1,32'h3,32'h1003,3'd1));
      // Fill with decode stalled, then a one-cycle pop
      tbl.push_back(mk(1,0,32'h0,   0, 0,1,32'h0,0,32'h0,32'h0,   3'd0));
      tbl.push_back(mk(0,1,32'h1000,0, 1,1,32'h0,0,32'h0,32'h0,   3'd0));
      tbl.push_back(mk(0,1,32'h1000,0, 1,1,32'h1,1,32'h0,32'h1000,3'd1));
      tbl.push_back(mk(0,1,32'h1001,0, 1,1,32'h2,1,32'h0,32'h1000,3'd2));
      tbl.push_back(mk(0,1,32'h1002,0, 1,1,32'h3,1,32'h0,32'h1000,3'd3));
      tbl.push_back(mk(0,1,32'h1003,0, 0,0,32'h0,1,32'h0,32'h1000,3'd4));
      tbl.push_back(mk(0,1,32'h1004,0, 0,0,32'h0,1,32'h0,32'h1000,3'd4));
      tbl.push_back(mk(0,1,32'h1004,1, 0,0,32'h0,1,32'h1,32'h1001,3'd3));
      tbl.push_back(mk(0,1,32'h1004,0, 1,1,32'h4,1,32'h1,32'h1001,3'd3));
      tbl.push_back(mk(0,1,32'h1004,0, 0,0,32'h0,1,32'h1,32'h1001,3'd4));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         else step(tbl[i].ack, tbl[i].rdata, tbl[i].ready, 1'b0, 32'h0);
         check_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // Redirect while a request is outstanding: old data must be dropped
      do_reset();
      step(0, 32'h0, 0, 0, 32'h0);
      check_vec("rdA0", mk(0,0,0,0, 1,1,32'h0,0,0,0,3'd0));
      step(0, 32'h0, 0, 1, 32'h80);
      check_vec("rdA1", mk(0,0,0,0, 1,1,32'h0,0,0,0,3'd0));
      step(0, 32'h0, 0, 0, 32'h0);
      check_vec("rdA2", mk(0,0,0,0, 1,1,32'h0,0,0,0,3'd0));
      step(0, 32'h0, 0, 0, 32'h0);
      check_vec("rdA3", mk(0,0,0,0, 1,1,32'h0,0,0,0,3'd0));
      step(1, 32'hDEAD, 0, 0, 32'h0);
      check_vec("rdA4", mk(0,0,0,0, 1,1,32'h80,0,0,0,3'd0));
      step(1, 32'hBEEF0080, 0, 0, 32'h0);
      check_vec("rdA5", mk(0,0,0,0, 1,1,32'h81,1,32'h80,32'hBEEF0080,3'd1));

      // Redirect coinciding with pop and ack at count 2
      do_reset();
      step(1, 32'h0, 0, 0, 32'h0);
      step(1, 32'h1000, 0, 0, 32'h0);
      step(1, 32'h1001, 0, 0, 32'h0);
      check_vec("rdB0", mk(0,0,0,0, 1,1,32'h2,1,32'h0,32'h1000,3'd2));
      step(1, 32'h1002, 1, 1, 32'h40);
      check_vec("rdB1", mk(0,0,0,0, 1,1,32'h40,0,0,0,3'd0));
      step(1, 32'h2040, 1, 0, 32'h0);
      check_vec("rdB2", mk(0,0,0,0, 1,1,32'h41,1,32'h40,32'h2040,3'd1));

      // Fetch PC wraps at the top of the address space
      do_reset();
      step(0, 32'h0, 1, 1, 32'hFFFF_FFFF);
      check_vec("wrap0", mk(0,0,0,0, 0,0,32'h0,0,0,0,3'd0));
      step(0, 32'h0, 1, 0, 32'h0);
      check_vec("wrap1", mk(0,0,0,0, 1,1,32'hFFFF_FFFF,0,0,0,3'd0));
      step(1, 32'hA, 1, 0, 32'h0);
      check_vec("wrap2", mk(0,0,0,0, 1,1,32'h0,1,32'hFFFF_FFFF,32'hA,3'd1));
      step(1, 32'hB, 1, 0, 32'h0);
      check_vec("wrap3", mk(0,0,0,0, 1,1,32'h1,1,32'h0,32'hB,3'd1));

      // Asynchronous reset in the middle of a request
      do_reset();
      step(1, 32'h0, 0, 0, 32'h0);
      step(1, 32'h1000, 0, 0, 32'h0);
      check_vec("ares0", mk(0,0,0,0, 1,1,32'h1,1,32'h0,32'h1000,3'd1));
      reset = 1'b1;
      #1;
      chk("ares mem_req",   32'(mem_req),   32'h0);
      chk("ares count",     32'(count),     32'h0);
      chk("ares out_valid", 32'(out_valid), 32'h0);
      mem_ack = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      step(0, 32'h0, 0, 0, 32'h0);
      check_vec("ares1", mk(0,0,0,0, 1,1,32'h0,0,0,0,3'd0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
